// File: rtl/hazard_ctrl.sv
// Hazard unit for a five-stage pipeline: operand forwarding, load/branch interlocks
// and a multi-cycle multiply occupancy FSM, with private copies of the M/W destinations.
module hazard_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic       RegWriteE,
    input  logic       MemtoRegE,
    input  logic       BranchD,
    input  logic       MultE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushE
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_cnt;

    logic [4:0] r_write_reg_m;
    logic       r_reg_write_m;
    logic       r_mem_to_reg_m;
    logic [4:0] r_write_reg_w;
    logic       r_reg_write_w;

    logic       w_stall_e;
    logic       w_lwstall;
    logic       w_branchstall;
    logic       w_hold;

    logic [4:0] w_src_e   [2];
    logic [4:0] w_src_d   [2];
    logic [1:0] w_fwd_e   [2];
    logic       w_fwd_d   [2];
    logic       w_br_dep  [2];

    // Multiply occupancy: one stall cycle entering BUSY, two while cnt counts down,
    // and a final free cycle at cnt==0 where the result leaves E.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (MultE) begin
                        r_cnt   <= 2'd2;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != 2'd0) begin
                        r_cnt <= r_cnt - 2'd1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 2'd0;
                end
            endcase
        end
    end

    assign w_stall_e = (r_state == S_IDLE) ? MultE : (r_cnt != 2'd0);

    // A held E stage sends a bubble into M so its destination is never forwarded twice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_write_reg_m  <= 5'd0;
            r_reg_write_m  <= 1'b0;
            r_mem_to_reg_m <= 1'b0;
            r_write_reg_w  <= 5'd0;
            r_reg_write_w  <= 1'b0;
        end else begin
            if (w_stall_e) begin
                r_write_reg_m  <= 5'd0;
                r_reg_write_m  <= 1'b0;
                r_mem_to_reg_m <= 1'b0;
            end else begin
                r_write_reg_m  <= WriteRegE;
                r_reg_write_m  <= RegWriteE;
                r_mem_to_reg_m <= MemtoRegE;
            end
            r_write_reg_w <= r_write_reg_m;
            r_reg_write_w <= r_reg_write_m;
        end
    end

    assign w_src_e[0] = RsE;
    assign w_src_e[1] = RtE;
    assign w_src_d[0] = RsD;
    assign w_src_d[1] = RtD;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            always_comb begin
                w_fwd_e[gi] = 2'b00;
                if (w_src_e[gi] != 5'd0 && w_src_e[gi] == r_write_reg_m && r_reg_write_m) begin
                    w_fwd_e[gi] = 2'b10;
                end else if (w_src_e[gi] != 5'd0 && w_src_e[gi] == r_write_reg_w && r_reg_write_w) begin
                    w_fwd_e[gi] = 2'b01;
                end
            end

            assign w_fwd_d[gi] = (w_src_d[gi] != 5'd0) && (w_src_d[gi] == r_write_reg_m) && r_reg_write_m;

            // A branch operand is unavailable if an ALU result is still in E or a load result in M.
            assign w_br_dep[gi] = (RegWriteE && WriteRegE != 5'd0 && WriteRegE == w_src_d[gi]) ||
                                  (r_mem_to_reg_m && r_write_reg_m != 5'd0 && r_write_reg_m == w_src_d[gi]);
        end
    endgenerate

    assign w_lwstall     = MemtoRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));
    assign w_branchstall = BranchD && (w_br_dep[0] || w_br_dep[1]);
    assign w_hold        = w_lwstall | w_branchstall;

    assign ForwardAE = w_fwd_e[0];
    assign ForwardBE = w_fwd_e[1];
    assign ForwardAD = w_fwd_d[0];
    assign ForwardBD = w_fwd_d[1];
    assign StallE    = w_stall_e;
    assign StallF    = w_hold | w_stall_e;
    assign StallD    = w_hold | w_stall_e;
    assign FlushE    = w_hold & ~w_stall_e;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a per-cycle reference model plus literal spot checks.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE;
    logic       RegWriteE, MemtoRegE, BranchD, MultE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       ForwardAD, ForwardBD, StallF, StallD, StallE, FlushE;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .BranchD(BranchD), .MultE(MultE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushE(FlushE)
    );

    always #5 clk = ~clk;

    // Reference model: what occupies M and W, and how many cycles the multiply still owns E.
    int m_reg, m_rw, m_ld, w_reg, w_rw;
    int mult_left;
    bit model_valid = 1'b0;

    function automatic bit exp_stall_e();
        return (mult_left == 0) ? MultE : (mult_left >= 2);
    endfunction

    function automatic int exp_fwd_e(input int src);
        if (src != 0 && src == m_reg && m_rw != 0) return 2;
        if (src != 0 && src == w_reg && w_rw != 0) return 1;
        return 0;
    endfunction

    function automatic bit exp_fwd_d(input int src);
        return src != 0 && src == m_reg && m_rw != 0;
    endfunction

    function automatic bit exp_lw();
        return MemtoRegE && RtE != 0 && (RtE == RsD || RtE == RtD);
    endfunction

    function automatic bit exp_br();
        bit e_dep, m_dep;
        e_dep = RegWriteE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD);
        m_dep = m_ld != 0 && m_reg != 0 && (m_reg == RsD || m_reg == RtD);
        return BranchD && (e_dep || m_dep);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_reg <= 0; m_rw <= 0; m_ld <= 0; w_reg <= 0; w_rw <= 0;
            mult_left   <= 0;
            model_valid <= 1'b1;
        end else if (model_valid) begin
            if (exp_stall_e()) begin
                m_reg <= 0; m_rw <= 0; m_ld <= 0;
            end else begin
                m_reg <= int'(WriteRegE); m_rw <= int'(RegWriteE); m_ld <= int'(MemtoRegE);
            end
            w_reg <= m_reg; w_rw <= m_rw;
            if (mult_left > 0) mult_left <= mult_left - 1;
            else if (MultE)    mult_left <= 3;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (model_valid) begin
            bit se, hold;
            se   = exp_stall_e();
            hold = exp_lw() || exp_br();
            chk("model_ForwardAE", int'(ForwardAE), exp_fwd_e(int'(RsE)));
            chk("model_ForwardBE", int'(ForwardBE), exp_fwd_e(int'(RtE)));
            chk("model_ForwardAD", int'(ForwardAD), int'(exp_fwd_d(int'(RsD))));
            chk("model_ForwardBD", int'(ForwardBD), int'(exp_fwd_d(int'(RtD))));
            chk("model_StallE",    int'(StallE),    int'(se));
            chk("model_StallF",    int'(StallF),    int'(hold || se));
            chk("model_StallD",    int'(StallD),    int'(hold || se));
            chk("model_FlushE",    int'(FlushE),    int'(hold && !se));
            $display("cyc=%0d rst_n=%0b fAE=%0d fBE=%0d fAD=%0b fBD=%0b sF=%0b sD=%0b sE=%0b fl=%0b",
                     cyc, rst_n, ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, StallE, FlushE);
        end
    end

    task automatic clr();
        rst_n = 1'b1;
        RsD = 5'd0; RtD = 5'd0; RsE = 5'd0; RtE = 5'd0; WriteRegE = 5'd0;
        RegWriteE = 1'b0; MemtoRegE = 1'b0; BranchD = 1'b0; MultE = 1'b0;
    endtask

    task automatic next_vec();
        @(posedge clk); #1;
        clr();
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        // Reset, then idle outputs
        next_vec(); rst_n = 1'b0; settle();
        next_vec(); settle();
        chk("rst_fwd", int'({ForwardAE, ForwardBE, ForwardAD, ForwardBD}), 0);
        chk("rst_stall", int'({StallF, StallD, StallE, FlushE}), 0);

        // E writes r5, then consumer in E via M, then via W
        next_vec(); RegWriteE = 1'b1; WriteRegE = 5'd5; settle();
        next_vec(); RsE = 5'd5; settle();
        chk("fwdA_from_M", int'(ForwardAE), 2);
        next_vec(); RtE = 5'd5; settle();
        chk("fwdB_from_W", int'(ForwardBE), 1);

        // M has priority over W
        next_vec(); RegWriteE = 1'b1; WriteRegE = 5'd7; settle();
        next_vec(); RegWriteE = 1'b1; WriteRegE = 5'd7; settle();
        next_vec(); RsE = 5'd7; settle();
        chk("fwd_M_priority", int'(ForwardAE), 2);

        // Load-use interlock lasts one cycle
        next_vec(); MemtoRegE = 1'b1; RegWriteE = 1'b1; RtE = 5'd8; WriteRegE = 5'd8; RsD = 5'd8; settle();
        chk("lw_stall", int'({StallF, StallD, FlushE, StallE}), 4'b1110);
        next_vec(); RsE = 5'd8; settle();
        chk("lw_release", int'({StallF, StallD, FlushE}), 0);
        chk("lw_fwdA", int'(ForwardAE), 2);

        // Writes to r0 are never forwarded nor interlocked
        next_vec(); RegWriteE = 1'b1; WriteRegE = 5'd0; BranchD = 1'b1; settle();
        chk("r0_no_branchstall", int'(StallF), 0);
        next_vec(); RsE = 5'd0; settle();
        chk("r0_no_fwd", int'(ForwardAE), 0);
        chk("r0_no_stall", int'({StallF, FlushE}), 0);

        // Branch depends on an ALU result in E, then forwards it from M
        next_vec(); BranchD = 1'b1; RsD = 5'd3; RegWriteE = 1'b1; WriteRegE = 5'd3; settle();
        chk("br_stall", int'({StallF, StallD, FlushE}), 3'b111);
        next_vec(); BranchD = 1'b1; RsD = 5'd3; settle();
        chk("br_fwdAD", int'(ForwardAD), 1);
        chk("br_release", int'(StallF), 0);

        // Multiply: three stall cycles with bubbles in M, free on the fourth
        for (int i = 0; i < 4; i++) begin
            next_vec(); MultE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd9; RsE = (i == 0) ? 5'd0 : 5'd9; settle();
            chk("mult_StallE", int'(StallE), (i < 3) ? 1 : 0);
            chk("mult_bubble_fwd", int'(ForwardAE), 0);
            chk("mult_no_flush", int'(FlushE), 0);
        end
        next_vec(); RsE = 5'd9; settle();
        chk("mult_result_fwd", int'(ForwardAE), 2);

        // Multiply together with a load: multiply wins, load still holds F/D
        next_vec(); MultE = 1'b1; MemtoRegE = 1'b1; RtE = 5'd4; RsD = 5'd4; settle();
        chk("mult_lw", int'({StallE, StallF, StallD, FlushE}), 4'b1110);
        for (int i = 0; i < 3; i++) begin
            next_vec(); MultE = 1'b1; settle();
            chk("mult_lw_tail", int'(StallE), (i < 2) ? 1 : 0);
        end

        // Reset mid-multiply at cnt==1
        next_vec(); MultE = 1'b1; settle();
        next_vec(); settle();
        next_vec(); rst_n = 1'b0; settle();
        chk("mult_before_rst", int'(StallE), 1);
        next_vec(); settle();
        chk("rst_abort_mult", int'({StallE, StallF}), 0);

        // Reset clears the M shadow
        next_vec(); RegWriteE = 1'b1; WriteRegE = 5'd6; rst_n = 1'b0; settle();
        next_vec(); RsE = 5'd6; settle();
        chk("rst_clears_M", int'(ForwardAE), 0);
        next_vec(); RsE = 5'd6; settle();
        chk("rst_clears_W", int'(ForwardAE), 0);

        next_vec(); settle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
